// File: rtl/minisys_mem_stage.sv
// rtl/minisys_mem_stage.sv - Minisys MEM->WB stage: byte-lane data RAM, stalling IO port, load extension
// Optional feature: MEM_IO_TIMEOUT_EN (IO_WAIT bus-error timeout).
module minisys_mem_stage #(
  parameter int         ADDR_W     = 14,
  parameter logic [7:0] IO_HI      = 8'hFF,
  parameter int         IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        m_valid,
  input  logic        m_regwrite,
  input  logic        m_mem2reg,
  input  logic        m_load,
  input  logic        m_store,
  input  logic        m_signed,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [4:0]  m_wreg,
  input  logic [31:0] m_pcplus4,
  output logic        stall_o,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        w_valid,
  output logic        w_regwrite,
  output logic        w_mem2reg,
  output logic [4:0]  w_wreg,
  output logic [31:0] w_alu,
  output logic [31:0] w_rdata,
  output logic [31:0] w_pcplus4,
  output logic        misalign_o,
  output logic [31:0] misalign_addr
);

  typedef enum logic [1:0] {IDLE, IO_WAIT, IO_DONE} state_t;
  state_t state;

  logic [1:0]        off;
  logic              ioHit, isHalf, isWord, mis, ioStart, ramWe;
  logic [3:0]        be;
  logic [31:0]       laneData;
  logic [ADDR_W-1:0] ramIdx;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       ramQ, ioRd;
  logic              wLoad, wFromIo, wSigned;
  logic [1:0]        wOff, wSize;
  logic              busErr;

`ifdef MEM_IO_TIMEOUT_EN
  localparam int TO_W = $clog2(IO_TIMEOUT + 1);
  logic [TO_W-1:0] toCnt;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^IO_TIMEOUT;
  assign busErr = 1'b0;
`endif

  // Misalignment only matters for real memory accesses, not ALU results.
  always_comb begin
    off     = m_addr[1:0];
    ramIdx  = m_addr[ADDR_W+1:2];
    ioHit   = (m_addr[31:24] == IO_HI);
    isHalf  = (m_size == 2'd1);
    isWord  = m_size[1];
    mis     = (m_load || m_store) && ((isHalf && off[0]) || (isWord && off != 2'd0));
    ioStart = m_valid && (m_load || m_store) && ioHit && !mis;
    stall_o = (state == IDLE && ioStart) || state == IO_WAIT;
    ramWe   = m_valid && m_store && !ioHit && !mis && !stall_o && !clr;
  end

  always_comb begin
    be       = 4'hF;
    laneData = m_wdata;
    if (m_size == 2'd0) begin
      be       = 4'b0001 << off;
      laneData = {4{m_wdata[7:0]}};
    end else if (isHalf) begin
      be       = 4'b0011 << off;
      laneData = {2{m_wdata[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) ram[ramIdx][8*k +: 8] <= laneData[8*k +: 8];
      end
    end
    ramQ <= ram[ramIdx];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_be    <= 4'h0;
      io_addr  <= 32'd0;
      io_wdata <= 32'd0;
      ioRd     <= 32'd0;
`ifdef MEM_IO_TIMEOUT_EN
      toCnt    <= '0;
      busErr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (ioStart) begin
          state    <= IO_WAIT;
          io_req   <= 1'b1;
          io_addr  <= m_addr;
          io_wdata <= laneData;
          io_be    <= be;
          io_we    <= m_store;
`ifdef MEM_IO_TIMEOUT_EN
          toCnt    <= '0;
          busErr   <= 1'b0;
`endif
        end
        IO_WAIT: if (io_ack) begin
          ioRd   <= io_rdata;
          state  <= IO_DONE;
          io_req <= 1'b0;
          io_we  <= 1'b0;
          io_be  <= 4'h0;
        end
`ifdef MEM_IO_TIMEOUT_EN
        else if (toCnt == TO_W'(IO_TIMEOUT - 1)) begin
          ioRd   <= 32'hDEAD_BEEF;
          busErr <= 1'b1;
          state  <= IO_DONE;
          io_req <= 1'b0;
          io_we  <= 1'b0;
          io_be  <= 4'h0;
        end else begin
          toCnt <= toCnt + TO_W'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // IO_DONE retires the held instruction even though stall_o has dropped.
  always_ff @(posedge clk) begin
    if (clr || (state != IO_DONE && (stall_o || !m_valid))) begin
      w_valid       <= 1'b0;
      w_regwrite    <= 1'b0;
      w_mem2reg     <= 1'b0;
      w_wreg        <= 5'd0;
      w_alu         <= 32'd0;
      w_pcplus4     <= 32'd0;
      misalign_o    <= 1'b0;
      misalign_addr <= 32'd0;
      wLoad         <= 1'b0;
      wFromIo       <= 1'b0;
      wOff          <= 2'd0;
      wSize         <= 2'd0;
      wSigned       <= 1'b0;
    end else begin
      w_valid   <= 1'b1;
      w_mem2reg <= m_mem2reg;
      w_wreg    <= m_wreg;
      w_alu     <= m_addr;
      w_pcplus4 <= m_pcplus4;
      wOff      <= off;
      wSize     <= m_size;
      wSigned   <= m_signed;
      if (state == IO_DONE) begin
        w_regwrite    <= m_regwrite && !busErr;
        misalign_o    <= busErr;
        misalign_addr <= busErr ? m_addr : 32'd0;
        wLoad         <= m_load;
        wFromIo       <= 1'b1;
      end else begin
        w_regwrite    <= m_regwrite && !mis;
        misalign_o    <= mis;
        misalign_addr <= mis ? m_addr : 32'd0;
        wLoad         <= m_load && !mis;
        wFromIo       <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] o,
                                         input logic [1:0] sz, input logic sgn);
    logic [31:0] sh;
    sh = raw >> {o, 3'b000};
    case (sz)
      2'd0:    extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: extend = raw;
    endcase
  endfunction

  always_comb begin
    w_rdata = 32'd0;
    if (wLoad) w_rdata = extend(wFromIo ? ioRd : ramQ, wOff, wSize, wSigned);
  end

endmodule

// File: tb/tb_minisys_mem_stage.sv
// tb/tb_minisys_mem_stage.sv - directed self-checking bench for minisys_mem_stage
`timescale 1ns/1ps
module tb_minisys_mem_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        m_valid, m_regwrite, m_mem2reg, m_load, m_store, m_signed;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_pcplus4;
  logic [4:0]  m_wreg;
  logic        stall_o, io_req, io_we, io_ack;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [3:0]  io_be;
  logic        w_valid, w_regwrite, w_mem2reg, misalign_o;
  logic [4:0]  w_wreg;
  logic [31:0] w_alu, w_rdata, w_pcplus4, misalign_addr;

  always #5 clk = ~clk;

  minisys_mem_stage dut (
    .clk(clk), .clr(clr), .m_valid(m_valid), .m_regwrite(m_regwrite), .m_mem2reg(m_mem2reg),
    .m_load(m_load), .m_store(m_store), .m_signed(m_signed), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wreg(m_wreg), .m_pcplus4(m_pcplus4), .stall_o(stall_o),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
    .io_rdata(io_rdata), .io_ack(io_ack), .w_valid(w_valid), .w_regwrite(w_regwrite),
    .w_mem2reg(w_mem2reg), .w_wreg(w_wreg), .w_alu(w_alu), .w_rdata(w_rdata),
    .w_pcplus4(w_pcplus4), .misalign_o(misalign_o), .misalign_addr(misalign_addr)
  );

  typedef struct packed {
    logic        valid, rw, m2r;
    logic [4:0]  wreg;
    logic [31:0] alu, rdata, pc;
    logic        mis;
    logic [31:0] misAddr;
  } wres_t;

  wres_t       ew, nw;
  logic        eStall, eReq, eWe;
  logic [3:0]  eBe;
  logic [31:0] eIoAddr, eIoData, eIoMask;
  bit          chkOn = 0;
  int          total = 0, bad = 0;
  int          ioStall, ioReqCnt;
  int unsigned pcCnt = 32'h400;
  logic [7:0]  mm [int];
  bit          litOn [2];
  string       litNm [2];
  int          litSel [2];
  logic [31:0] litVal [2];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] memWord(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = mm.exists((a & ~3) + k) ? mm[(a & ~3) + k] : 8'h00;
    return w;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] word, input logic [1:0] off,
                                       input logic [1:0] sz, input logic sgn);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off + i) +: 8];
    if (sgn && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chkOn) begin
    chk("w_valid", 32'(w_valid), 32'(ew.valid));
    chk("w_regwrite", 32'(w_regwrite), 32'(ew.rw));
    chk("w_mem2reg", 32'(w_mem2reg), 32'(ew.m2r));
    chk("w_wreg", 32'(w_wreg), 32'(ew.wreg));
    chk("w_alu", w_alu, ew.alu);
    chk("w_rdata", w_rdata, ew.rdata);
    chk("w_pcplus4", w_pcplus4, ew.pc);
    chk("misalign_o", 32'(misalign_o), 32'(ew.mis));
    chk("misalign_addr", misalign_addr, ew.misAddr);
    chk("stall_o", 32'(stall_o), 32'(eStall));
    chk("io_req", 32'(io_req), 32'(eReq));
    if (eReq) begin
      chk("io_addr", io_addr, eIoAddr);
      chk("io_we", 32'(io_we), 32'(eWe));
      chk("io_be", 32'(io_be), 32'(eBe));
      if (eWe) chk("io_wdata", io_wdata & eIoMask, eIoData);
    end
    for (int s = 0; s < 2; s++) if (litOn[s]) begin
      case (litSel[s])
        0: chk(litNm[s], w_rdata, litVal[s]);
        1: chk(litNm[s], misalign_addr, litVal[s]);
        2: chk(litNm[s], 32'(ioStall), litVal[s]);
        3: chk(litNm[s], 32'(ioReqCnt), litVal[s]);
        default: chk(litNm[s], {27'd0, io_we, io_be}, litVal[s]);
      endcase
    end
  end

  task automatic lit(input int s, input string nm, input int sel, input logic [31:0] v);
    litOn[s] = 1; litNm[s] = nm; litSel[s] = sel; litVal[s] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ew = nw;
    litOn[0] = 0;
    litOn[1] = 0;
  endtask

  task automatic issue(input bit v, ld, st, sg, rw, m2r, input logic [1:0] sz,
                       input logic [31:0] a, wd, input logic [4:0] wr);
    bit ms;
    ms = (ld || st) && misal(a, sz);
    pcCnt += 4;
    m_valid = v; m_load = ld; m_store = st; m_signed = sg; m_regwrite = rw; m_mem2reg = m2r;
    m_size = sz; m_addr = a; m_wdata = wd; m_wreg = wr; m_pcplus4 = pcCnt;
    eStall = 0; eReq = 0;
    nw = '0;
    if (v) begin
      nw.valid = 1; nw.rw = rw && !ms; nw.m2r = m2r; nw.wreg = wr; nw.alu = a;
      nw.pc = pcCnt; nw.mis = ms; nw.misAddr = ms ? a : 32'd0;
      if (ld && !ms) nw.rdata = pick(memWord(a), a[1:0], sz, sg);
      if (st && !ms) for (int i = 0; i < nbytes(sz); i++) mm[a + i] = wd[8*i +: 8];
    end
    tick();
  endtask

  task automatic setIo(input bit st, sg, rw, input logic [1:0] sz, input logic [31:0] a, wd,
                       input logic [4:0] wr);
    pcCnt += 4;
    m_valid = 1; m_load = !st; m_store = st; m_signed = sg; m_regwrite = rw; m_mem2reg = !st;
    m_size = sz; m_addr = a; m_wdata = wd; m_wreg = wr; m_pcplus4 = pcCnt;
    eIoAddr = a; eWe = st; eBe = '0; eIoMask = '0; eIoData = '0;
    for (int i = 0; i < nbytes(sz); i++) begin
      eBe[a[1:0] + i] = 1'b1;
      eIoMask[8*(a[1:0] + i) +: 8] = 8'hFF;
      eIoData[8*(a[1:0] + i) +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
    if (stall_o) ioStall++;
    if (io_req) ioReqCnt++;
  endtask

  task automatic ioAccess(input bit st, sg, rw, input logic [1:0] sz, input logic [31:0] a, wd,
                          input logic [4:0] wr, input int waits, input bit ack,
                          input logic [31:0] rd);
    logic [31:0] data;
    bit to;
    setIo(st, sg, rw, sz, a, wd, wr);
    ioStall = 0; ioReqCnt = 0;
    eStall = 1; eReq = 0; nw = '0;
    sample(); tick();
    for (int i = 1; i <= waits; i++) begin
      io_ack   = ack && (i == waits);
      io_rdata = io_ack ? rd : 32'h0BAD_0000 + i;
      eStall = 1; eReq = 1; nw = '0;
      sample(); tick();
    end
    // a stray ack in IO_DONE must not replace the captured data
    io_ack = 1; io_rdata = 32'h5555_AAAA;
    eStall = 0; eReq = 0;
    to   = !ack;
    data = ack ? rd : 32'hDEAD_BEEF;
    nw = '0;
    nw.valid = 1; nw.rw = rw && !to; nw.m2r = !st; nw.wreg = wr; nw.alu = a; nw.pc = pcCnt;
    nw.mis = to; nw.misAddr = to ? a : 32'd0;
    nw.rdata = st ? 32'd0 : pick(data, a[1:0], sz, sg);
    sample(); tick();
    io_ack = 0; io_rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clr = 1; io_ack = 0; io_rdata = 0;
    m_valid = 0; m_regwrite = 0; m_mem2reg = 0; m_load = 0; m_store = 0; m_signed = 0;
    m_size = 0; m_addr = 0; m_wdata = 0; m_wreg = 0; m_pcplus4 = 0;
    nw = '0; ew = '0; eStall = 0; eReq = 0; eWe = 0; eBe = 0;
    eIoAddr = 0; eIoData = 0; eIoMask = 0; ioStall = 0; ioReqCnt = 0;
    litOn[0] = 0; litOn[1] = 0;
    tick(); chkOn = 1; tick();
    clr = 0;
    lit(0, "reset_io_we_be", 4, 32'd0);
    lit(1, "reset_misalign_addr", 1, 32'd0);

    // word store then byte loads straight after it
    issue(1, 0, 1, 0, 0, 0, 2'd2, 32'h10, 32'h8899AABB, 5'd0);
    issue(1, 1, 0, 1, 1, 1, 2'd0, 32'h11, 32'h0, 5'd5);
    lit(0, "lb_signed", 0, 32'hFFFF_FFAA);
    issue(1, 1, 0, 0, 1, 1, 2'd0, 32'h11, 32'h0, 5'd6);
    lit(0, "lbu", 0, 32'h0000_00AA);

    // halfword store merges into an existing word
    issue(1, 0, 1, 0, 0, 0, 2'd2, 32'h20, 32'h01020304, 5'd0);
    issue(1, 0, 1, 0, 0, 0, 2'd2, 32'h04, 32'h11223344, 5'd0);
    issue(1, 0, 1, 0, 0, 0, 2'd1, 32'h22, 32'hABCD1234, 5'd0);
    issue(1, 1, 0, 0, 1, 1, 2'd2, 32'h20, 32'h0, 5'd7);
    lit(0, "sh_then_lw", 0, 32'h1234_0304);

    // misaligned store and load leave RAM untouched
    issue(1, 0, 1, 0, 0, 0, 2'd1, 32'h21, 32'h0000BEEF, 5'd0);
    lit(1, "mis_sh_addr", 1, 32'h21);
    issue(1, 1, 0, 1, 1, 1, 2'd1, 32'h23, 32'h0, 5'd8);
    lit(1, "mis_lh_addr", 1, 32'h23);
    issue(1, 1, 0, 0, 1, 1, 2'd2, 32'h20, 32'h0, 5'd9);
    lit(0, "ram_unchanged", 0, 32'h1234_0304);

    // byte store, half loads, size 3 behaves as word
    issue(1, 0, 1, 0, 0, 0, 2'd0, 32'h13, 32'h777777F0, 5'd0);
    issue(1, 1, 0, 1, 1, 1, 2'd1, 32'h12, 32'h0, 5'd10);
    lit(0, "lh_signed", 0, 32'hFFFF_F099);
    issue(1, 1, 0, 0, 1, 1, 2'd1, 32'h12, 32'h0, 5'd11);
    issue(1, 1, 0, 1, 1, 1, 2'd3, 32'h10, 32'h0, 5'd12);
    lit(0, "size3_word", 0, 32'hF099_AABB);

    // ALU op with odd address is not a misaligned access; invalid store writes nothing
    issue(1, 0, 0, 0, 1, 0, 2'd2, 32'hFF00_0003, 32'h0, 5'd13);
    issue(0, 0, 1, 0, 0, 0, 2'd2, 32'h10, 32'hFFFFFFFF, 5'd0);
    issue(1, 1, 0, 0, 1, 1, 2'd2, 32'h10, 32'h0, 5'd14);

    // IO word load, ack on the fourth wait cycle
    ioAccess(0, 0, 1, 2'd2, 32'hFF00_0004, 32'h0, 5'd15, 4, 1, 32'hCAFE_F00D);
    lit(0, "io_stall_cycles", 2, 32'd5);
    lit(1, "io_req_cycles", 3, 32'd4);
    issue(1, 1, 0, 0, 1, 1, 2'd2, 32'h04, 32'h0, 5'd16);

    // minimum-length IO byte store, aliasing RAM word 1 which must not change
    ioAccess(1, 0, 0, 2'd0, 32'hFF00_0007, 32'h0000005A, 5'd0, 1, 1, 32'h0);
    lit(0, "io_min_stall", 2, 32'd2);
    issue(1, 1, 0, 0, 1, 1, 2'd2, 32'h04, 32'h0, 5'd17);
    lit(0, "io_store_no_ram", 0, 32'h1122_3344);
    ioAccess(0, 1, 1, 2'd1, 32'hFF00_0002, 32'h0, 5'd18, 2, 1, 32'h8001_7FFF);
    ioAccess(1, 0, 0, 2'd1, 32'hFF00_0000, 32'h0000A5C3, 5'd0, 3, 1, 32'h0);

    // misaligned IO access never issues
    issue(1, 1, 0, 1, 1, 1, 2'd2, 32'hFF00_0002, 32'h0, 5'd19);
    issue(1, 0, 1, 0, 0, 0, 2'd1, 32'hFF00_0001, 32'h1234, 5'd0);

    // reset in the middle of IO_WAIT abandons the access
    setIo(0, 0, 1, 2'd2, 32'hFF00_0010, 32'h0, 5'd20);
    eStall = 1; eReq = 0; nw = '0; tick();
    eReq = 1; tick();
    clr = 1; m_valid = 0; tick();
    clr = 0; eStall = 0; eReq = 0;
    lit(0, "clr_io_we_be", 4, 32'd0);
    issue(0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0);
    issue(0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0);

`ifdef MEM_IO_TIMEOUT_EN
    ioAccess(0, 0, 1, 2'd2, 32'hFF00_0008, 32'h0, 5'd21, 15, 0, 32'h0);
    lit(0, "timeout_rdata", 0, 32'hDEAD_BEEF);
    lit(1, "timeout_stall", 2, 32'd16);
`endif

    issue(0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0);
    issue(0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
